// File: rtl/pipe_mux_if.sv
// pipe_mux_if: producer/consumer handshake bundle for pipe_mux.
// The slave modport is the mux itself; the master modport is the side
// that supplies candidate words and consumes the selected one.
interface pipe_mux_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/pipe_mux.sv
// pipe_mux: NUM_IN:1 word multiplexer feeding a 2-entry skid buffer.
// The selected word is registered, so there is no combinational path from
// the producer side to the consumer side, and in_ready depends only on the
// buffer occupancy. Sustains one word per cycle while out_ready is high.
// Optional build macro PIPE_MUX_SELCHK_EN adds a sticky sel_err output that
// flags any accepted transfer whose select is out of range.
module pipe_mux #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic CLK,
    input  logic Reset,
`ifdef PIPE_MUX_SELCHK_EN
    output logic sel_err,
`endif
    pipe_mux_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } count_t;

    count_t           count;
    logic [WIDTH-1:0] head_p1;
    logic [WIDTH-1:0] tail_p1;
    logic [WIDTH-1:0] word_p0;
    logic             push;
    logic             pop;

    // Out-of-range selects (possible when NUM_IN is not a power of two)
    // yield an all-zero word rather than aliasing onto a real input.
    function automatic logic [WIDTH-1:0] select_word(
        input logic [NUM_IN*WIDTH-1:0] data,
        input logic [SEL_W-1:0]        s
    );
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (32'(s) == i) begin
                w = data[i*WIDTH +: WIDTH];
            end
        end
        return w;
    endfunction

    assign word_p0       = select_word(bus.in_data, bus.sel);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    assign bus.in_ready  = (count != FULL);
    assign bus.out_valid = (count != EMPTY);
    assign bus.out_data  = head_p1;

    // Stage p0 -> p1: occupancy FSM and head/tail storage of the skid buffer.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            count   <= EMPTY;
            head_p1 <= '0;
            tail_p1 <= '0;
        end else begin
            case (count)
                EMPTY: begin
                    if (push) begin
                        head_p1 <= word_p0;
                        count   <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_p1 <= word_p0;
                    end else if (push) begin
                        tail_p1 <= word_p0;
                        count   <= FULL;
                    end else if (pop) begin
                        count   <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_p1 <= tail_p1;
                        count   <= ONE;
                    end
                end
                default: begin
                    count <= EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_MUX_SELCHK_EN
    // Sticky flag for any accepted select outside 0..NUM_IN-1; only Reset clears it.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            sel_err <= 1'b0;
        end else if (push && (32'(bus.sel) >= NUM_IN)) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_mux.sv
// tb_pipe_mux: directed bench for pipe_mux. A queue-based FIFO model tracks
// what the 4-input instance must present; a second 3-input instance covers
// the out-of-range select behaviour (and sel_err when PIPE_MUX_SELCHK_EN is set).
module tb_pipe_mux;

    localparam int W = 16;

    logic clk;
    logic rst;
    logic started;

    int n_tests;
    int n_fail;

    pipe_mux_if #(.WIDTH(W), .NUM_IN(4), .SEL_W(2)) bus0 ();
    pipe_mux_if #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) bus3 ();

`ifdef PIPE_MUX_SELCHK_EN
    logic sel_err0;
    logic sel_err3;
`endif

    pipe_mux #(.WIDTH(W), .NUM_IN(4), .SEL_W(2)) u_dut (
        .CLK    (clk),
        .Reset  (rst),
`ifdef PIPE_MUX_SELCHK_EN
        .sel_err(sel_err0),
`endif
        .bus    (bus0)
    );

    pipe_mux #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .CLK    (clk),
        .Reset  (rst),
`ifdef PIPE_MUX_SELCHK_EN
        .sel_err(sel_err3),
`endif
        .bus    (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO of at most two words for the 4-input instance.
    logic [W-1:0] mq[$];

    always @(posedge clk) begin
        logic          do_push;
        logic          do_pop;
        logic [W-1:0]  w;
        if (rst) begin
            mq.delete();
        end else begin
            do_push = bus0.in_valid && (mq.size() < 2);
            do_pop  = (mq.size() > 0) && bus0.out_ready;
            w = (bus0.sel < 4) ? bus0.in_data[bus0.sel*W +: W] : '0;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(w);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("mdl_out_valid", 32'(bus0.out_valid), 32'(mq.size() > 0));
            check("mdl_in_ready", 32'(bus0.in_ready), 32'(mq.size() < 2));
            if (mq.size() > 0) begin
                check("mdl_out_data", 32'(bus0.out_data), 32'(mq[0]));
            end
        end
    end

    logic [W-1:0] stream_exp [4];

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        started  = 1'b0;
        rst      = 1'b1;
        bus0.in_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus0.sel       = '0;
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        bus3.in_data   = {16'h3333, 16'h2222, 16'h1111};
        bus3.sel       = '0;
        bus3.in_valid  = 1'b0;
        bus3.out_ready = 1'b1;
        stream_exp[0] = 16'h1111;
        stream_exp[1] = 16'h2222;
        stream_exp[2] = 16'h3333;
        stream_exp[3] = 16'h4444;

        // Reset then idle
        tick();
        started = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        check("rst_out_data", 32'(bus0.out_data), 32'h0000);

        // Single push, sel=2
        bus0.sel = 2'd2;
        bus0.in_valid = 1'b1;
        tick();
        bus0.in_valid = 1'b0;
        bus0.sel = 2'd1;
        check("single_data", 32'(bus0.out_data), 32'h3333);
        check("single_valid", 32'(bus0.out_valid), 32'd1);
        tick();
        check("single_valid_drop", 32'(bus0.out_valid), 32'd0);
        check("single_data_hold", 32'(bus0.out_data), 32'h3333);

        // Streaming at one word per cycle
        for (int i = 0; i < 4; i++) begin
            bus0.sel = 2'(i);
            bus0.in_valid = 1'b1;
            tick();
            check("stream_data", 32'(bus0.out_data), 32'(stream_exp[i]));
            check("stream_in_ready", 32'(bus0.in_ready), 32'd1);
        end
        bus0.in_valid = 1'b0;
        tick();
        check("stream_end_valid", 32'(bus0.out_valid), 32'd0);

        // Backpressure fills the buffer
        bus0.out_ready = 1'b0;
        bus0.sel = 2'd3;
        bus0.in_valid = 1'b1;
        tick();
        bus0.sel = 2'd0;
        tick();
        bus0.in_valid = 1'b0;
        check("bp_in_ready", 32'(bus0.in_ready), 32'd0);
        check("bp_head", 32'(bus0.out_data), 32'h4444);
        bus0.in_valid = 1'b1;
        bus0.sel = 2'd2;
        tick();
        bus0.in_valid = 1'b0;
        check("bp_full_hold", 32'(bus0.out_data), 32'h4444);
        bus0.out_ready = 1'b1;
        tick();
        check("bp_second", 32'(bus0.out_data), 32'h1111);
        check("bp_in_ready_back", 32'(bus0.in_ready), 32'd1);
        tick();
        check("bp_drained", 32'(bus0.out_valid), 32'd0);

        // ONE state with simultaneous push and pop
        bus0.out_ready = 1'b0;
        bus0.sel = 2'd1;
        bus0.in_valid = 1'b1;
        tick();
        check("pp_head0", 32'(bus0.out_data), 32'h2222);
        bus0.out_ready = 1'b1;
        bus0.sel = 2'd3;
        tick();
        bus0.in_valid = 1'b0;
        check("pp_head1", 32'(bus0.out_data), 32'h4444);
        check("pp_count_one", 32'(bus0.in_ready), 32'd1);
        check("pp_valid", 32'(bus0.out_valid), 32'd1);
        tick();
        check("pp_drained", 32'(bus0.out_valid), 32'd0);

        // Reset while FULL, with a push attempt during reset
        bus0.out_ready = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.sel = 2'd0;
        tick();
        bus0.sel = 2'd1;
        tick();
        check("full_before_rst", 32'(bus0.in_ready), 32'd0);
        rst = 1'b1;
        bus0.sel = 2'd2;
        tick();
        rst = 1'b0;
        bus0.in_valid = 1'b0;
        check("rstfull_valid", 32'(bus0.out_valid), 32'd0);
        check("rstfull_in_ready", 32'(bus0.in_ready), 32'd1);
        check("rstfull_data", 32'(bus0.out_data), 32'h0000);
        tick();
        check("rstfull_stays_empty", 32'(bus0.out_valid), 32'd0);

        // Irregular traffic against the FIFO model
        for (int c = 0; c < 300; c++) begin
            bus0.in_valid  = 1'($urandom_range(0, 1));
            bus0.out_ready = ($urandom_range(0, 3) != 0);
            bus0.sel       = 2'($urandom_range(0, 3));
            bus0.in_data   = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            tick();
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("soak_drained", 32'(bus0.out_valid), 32'd0);

        // 3-input instance: sel=3 is out of range
        bus3.sel = 2'd3;
        bus3.in_valid = 1'b1;
        tick();
        check("oor_data", 32'(bus3.out_data), 32'h0000);
        check("oor_valid", 32'(bus3.out_valid), 32'd1);
`ifdef PIPE_MUX_SELCHK_EN
        check("sel_err_set", 32'(sel_err3), 32'd1);
        check("sel_err_clean4", 32'(sel_err0), 32'd0);
`endif
        bus3.sel = 2'd2;
        tick();
        check("oor_next", 32'(bus3.out_data), 32'h3333);
`ifdef PIPE_MUX_SELCHK_EN
        check("sel_err_sticky", 32'(sel_err3), 32'd1);
`endif
        bus3.in_valid = 1'b0;
        tick();
        check("oor_drained", 32'(bus3.out_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef PIPE_MUX_SELCHK_EN
        check("sel_err_cleared", 32'(sel_err3), 32'd0);
`endif
        check("oor_rst_data", 32'(bus3.out_data), 32'h0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
